fault_detector: RTL and testbench

//   Front-end stage for the fault FSM. Accepts measurement samples (voltage, current,

---
 rtl/fdet_pkg.sv | 44 ++++
 rtl/fault_detector_if.sv | 11 +
 rtl/fdet_filter.sv | 37 +++
 rtl/fault_detector.sv | 122 ++++++++++++
 tb/tb_fault_detector.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fdet_pkg.sv
// Shared definitions for the fault detector: channel indices, threshold
// reset fill values and the hysteresis candidate compare.
package fdet_pkg;

  // Channel indices follow the fault FSM fault-id ordering (id - 1)
  localparam int CH_UV  = 0;
  localparam int CH_OV  = 1;
  localparam int CH_OT  = 2;
  localparam int CH_UC  = 3;
  localparam int NUM_CH = 4;

  // Threshold reset fill bits: upper limits reset to all-ones, lower to zero,
  // so no flag can assert until thresholds are programmed
  localparam logic THR_HIGH_FILL = 1'b1;
  localparam logic THR_LOW_FILL  = 1'b0;
  localparam logic HYST_FILL     = 1'b0;

  // Compare operand width; callers zero-extend W-bit values (W <= 32)
  localparam int CMP_W = 32;

  // Signed arithmetic wider than W+1 bits gives the same result as W+1 bits:
  // thr-hyst may go negative and thr+hyst may exceed the W-bit range, in
  // which case the release condition can never be met.
  function automatic logic cand_calc(input logic low_side,
                                     input logic flag,
                                     input logic [CMP_W-1:0] meas,
                                     input logic [CMP_W-1:0] thr,
                                     input logic [CMP_W-1:0] hyst);
    logic signed [CMP_W+1:0] m;
    logic signed [CMP_W+1:0] t;
    logic signed [CMP_W+1:0] h;
    logic cand;
    m = signed'({2'b00, meas});
    t = signed'({2'b00, thr});
    h = signed'({2'b00, hyst});
    if (low_side) begin
      cand = flag ? !(m > (t + h)) : (m < t);
    end else begin
      cand = flag ? !(m < (t - h)) : (m > t);
    end
    return cand;
  endfunction

endpackage

// File: rtl/fault_detector_if.sv
// Sample stream interface for the fault detector (no backpressure).
interface fault_detector_if #(parameter int W = 12);
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] v_meas;
  logic [W-1:0] i_meas;
  logic [W-1:0] t_meas;

  modport master (output s_valid, v_meas, i_meas, t_meas, input s_ready);
  modport slave  (input s_valid, v_meas, i_meas, t_meas, output s_ready);
endinterface

// File: rtl/fdet_filter.sv
// Debounce filter: a flag toggles only after N_FILT consecutive accepted
// samples disagree with it. Idle cycles hold the run count.
module fdet_filter #(
  parameter int N_FILT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic acc,
  input  logic cand,
  output logic flag
);

  localparam int CW = (N_FILT > 1) ? $clog2(N_FILT) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_FILT - 1);

  logic [CW-1:0] cnt;

  // Count disagreeing samples; toggle the flag on the last one of a run
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      flag <= 1'b0;
    end else if (acc) begin
      if (cand != flag) begin
        if (cnt == LAST) begin
          flag <= ~flag;
          cnt  <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/fault_detector.sv
// Fault detector front end: threshold/hysteresis compare, per-channel
// debounce, stale-stream detection and optional peak hold.
// Optional feature macro: FDET_PEAK_HOLD_EN (peak registers on peak_*).
module fault_detector
  import fdet_pkg::*;
#(
  parameter int W       = 12,
  parameter int N_FILT  = 3,
  parameter int P_STALE = 16
) (
  input  logic         clk,
  input  logic         rst,
  fault_detector_if.slave s,
  input  logic         cfg_we,
  input  logic [W-1:0] cfg_ov,
  input  logic [W-1:0] cfg_uv,
  input  logic [W-1:0] cfg_ot,
  input  logic [W-1:0] cfg_uc,
  input  logic [W-1:0] cfg_hyst,
  output logic         ov,
  output logic         uv,
  output logic         ot,
  output logic         uc,
  output logic         stale,
  input  logic         peak_clr,
  output logic [W-1:0] peak_v,
  output logic [W-1:0] peak_i,
  output logic [W-1:0] peak_t
);

  localparam int IW = $clog2(P_STALE + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(P_STALE);

  logic              accept;
  logic [W-1:0]      thr_ov, thr_uv, thr_ot, thr_uc, thr_hyst;
  logic [NUM_CH-1:0] cand;
  logic [NUM_CH-1:0] flags;
  logic [IW-1:0]     idle_cnt;

  assign s.s_ready = 1'b1;
  assign accept    = s.s_valid;

  // Threshold registers; a same-cycle sample still sees the old values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      thr_ov   <= {W{THR_HIGH_FILL}};
      thr_ot   <= {W{THR_HIGH_FILL}};
      thr_uc   <= {W{THR_HIGH_FILL}};
      thr_uv   <= {W{THR_LOW_FILL}};
      thr_hyst <= {W{HYST_FILL}};
    end else if (cfg_we) begin
      thr_ov   <= cfg_ov;
      thr_ot   <= cfg_ot;
      thr_uc   <= cfg_uc;
      thr_uv   <= cfg_uv;
      thr_hyst <= cfg_hyst;
    end
  end

  // Per-channel candidate, hysteresis direction chosen by the current flag
  always_comb begin
    cand         = '0;
    cand[CH_UV]  = cand_calc(1'b1, flags[CH_UV], 32'(s.v_meas), 32'(thr_uv), 32'(thr_hyst));
    cand[CH_OV]  = cand_calc(1'b0, flags[CH_OV], 32'(s.v_meas), 32'(thr_ov), 32'(thr_hyst));
    cand[CH_OT]  = cand_calc(1'b0, flags[CH_OT], 32'(s.t_meas), 32'(thr_ot), 32'(thr_hyst));
    cand[CH_UC]  = cand_calc(1'b0, flags[CH_UC], 32'(s.i_meas), 32'(thr_uc), 32'(thr_hyst));
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_filt
    fdet_filter #(.N_FILT(N_FILT)) u_filt (
      .clk  (clk),
      .rst  (rst),
      .acc  (accept),
      .cand (cand[c]),
      .flag (flags[c])
    );
  end

  assign uv = flags[CH_UV];
  assign ov = flags[CH_OV];
  assign ot = flags[CH_OT];
  assign uc = flags[CH_UC];

  // Idle counter saturating at P_STALE; any accept clears it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (accept) begin
      idle_cnt <= '0;
    end else if (idle_cnt != IDLE_MAX) begin
      idle_cnt <= idle_cnt + IW'(1);
    end
  end

  assign stale = (idle_cnt == IDLE_MAX);

`ifdef FDET_PEAK_HOLD_EN
  // Peak hold; a clear coinciding with an accept restarts from that sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_v <= '0;
      peak_i <= '0;
      peak_t <= '0;
    end else if (peak_clr) begin
      peak_v <= accept ? s.v_meas : '0;
      peak_i <= accept ? s.i_meas : '0;
      peak_t <= accept ? s.t_meas : '0;
    end else if (accept) begin
      peak_v <= (s.v_meas > peak_v) ? s.v_meas : peak_v;
      peak_i <= (s.i_meas > peak_i) ? s.i_meas : peak_i;
      peak_t <= (s.t_meas > peak_t) ? s.t_meas : peak_t;
    end
  end
`else
  logic peak_clr_unused;
  assign peak_clr_unused = peak_clr;
  assign peak_v = '0;
  assign peak_i = '0;
  assign peak_t = '0;
`endif

endmodule

// File: tb/tb_fault_detector.sv
// Testbench for fault_detector: directed vectors, a rule-level model of the
// flags/stale/peaks checked every cycle, plus hand-computed expectations.
module tb_fault_detector;
  import fdet_pkg::*;

  localparam int W       = 12;
  localparam int N_FILT  = 3;
  localparam int P_STALE = 16;

  logic clk = 1'b0;
  logic rst;
  logic cfg_we, peak_clr;
  logic [W-1:0] cfg_ov, cfg_uv, cfg_ot, cfg_uc, cfg_hyst;
  logic ov, uv, ot, uc, stale;
  logic [W-1:0] peak_v, peak_i, peak_t;

  fault_detector_if #(.W(W)) s_if ();

  fault_detector #(.W(W), .N_FILT(N_FILT), .P_STALE(P_STALE)) dut (
    .clk      (clk),
    .rst      (rst),
    .s        (s_if),
    .cfg_we   (cfg_we),
    .cfg_ov   (cfg_ov),
    .cfg_uv   (cfg_uv),
    .cfg_ot   (cfg_ot),
    .cfg_uc   (cfg_uc),
    .cfg_hyst (cfg_hyst),
    .ov       (ov),
    .uv       (uv),
    .ot       (ot),
    .uc       (uc),
    .stale    (stale),
    .peak_clr (peak_clr),
    .peak_v   (peak_v),
    .peak_i   (peak_i),
    .peak_t   (peak_t)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  bit check_en     = 1'b0;

  // One comparison: count it, report on disagreement
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Model state: flags, run lengths of disagreeing samples, thresholds, idle, peaks
  int m_flag[NUM_CH];
  int m_run[NUM_CH];
  int m_thr[NUM_CH];
  int m_hyst;
  int m_idle;
  int m_peak[3];
  int m_meas;
  bit m_cand;

  // Model: applies the detector rules to each accepted sample
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_flag[c] = 0;
        m_run[c]  = 0;
        m_thr[c]  = (c == CH_UV) ? 0 : 4095;
      end
      m_hyst = 0;
      m_idle = 0;
      for (int k = 0; k < 3; k++) m_peak[k] = 0;
    end else begin
      if (s_if.s_valid) begin
        for (int c = 0; c < NUM_CH; c++) begin
          m_meas = (c == CH_OT) ? int'(s_if.t_meas) :
                   (c == CH_UC) ? int'(s_if.i_meas) : int'(s_if.v_meas);
          if (c == CH_UV)
            m_cand = (m_flag[c] != 0) ? (m_meas <= m_thr[c] + m_hyst) : (m_meas < m_thr[c]);
          else
            m_cand = (m_flag[c] != 0) ? (m_meas >= m_thr[c] - m_hyst) : (m_meas > m_thr[c]);
          if (int'(m_cand) != m_flag[c]) begin
            m_run[c]++;
            if (m_run[c] == N_FILT) begin
              m_flag[c] = 1 - m_flag[c];
              m_run[c]  = 0;
            end
          end else begin
            m_run[c] = 0;
          end
        end
        m_idle = 0;
      end else if (m_idle < P_STALE) begin
        m_idle++;
      end
`ifdef FDET_PEAK_HOLD_EN
      if (peak_clr) begin
        m_peak[0] = s_if.s_valid ? int'(s_if.v_meas) : 0;
        m_peak[1] = s_if.s_valid ? int'(s_if.i_meas) : 0;
        m_peak[2] = s_if.s_valid ? int'(s_if.t_meas) : 0;
      end else if (s_if.s_valid) begin
        if (int'(s_if.v_meas) > m_peak[0]) m_peak[0] = int'(s_if.v_meas);
        if (int'(s_if.i_meas) > m_peak[1]) m_peak[1] = int'(s_if.i_meas);
        if (int'(s_if.t_meas) > m_peak[2]) m_peak[2] = int'(s_if.t_meas);
      end
`endif
      if (cfg_we) begin
        m_thr[CH_OV] = int'(cfg_ov);
        m_thr[CH_UV] = int'(cfg_uv);
        m_thr[CH_OT] = int'(cfg_ot);
        m_thr[CH_UC] = int'(cfg_uc);
        m_hyst       = int'(cfg_hyst);
      end
    end
  end

  // Compare process: every out-of-reset cycle, on the falling edge
  always @(negedge clk) begin
    if (check_en && !rst) begin
      checkOutput("cyc_ov",     32'(ov),     32'(m_flag[CH_OV]));
      checkOutput("cyc_uv",     32'(uv),     32'(m_flag[CH_UV]));
      checkOutput("cyc_ot",     32'(ot),     32'(m_flag[CH_OT]));
      checkOutput("cyc_uc",     32'(uc),     32'(m_flag[CH_UC]));
      checkOutput("cyc_stale",  32'(stale),  32'(m_idle >= P_STALE));
      checkOutput("cyc_sready", 32'(s_if.s_ready), 32'd1);
      checkOutput("cyc_peak_v", 32'(peak_v), 32'(m_peak[0]));
      checkOutput("cyc_peak_i", 32'(peak_i), 32'(m_peak[1]));
      checkOutput("cyc_peak_t", 32'(peak_t), 32'(m_peak[2]));
    end
  end

  // Drive one cycle of inputs, then land just after the active edge
  task automatic applyStimulus(input bit valid, input int v, input int i, input int t,
                               input bit we = 1'b0, input bit pclr = 1'b0);
    s_if.s_valid = valid;
    s_if.v_meas  = W'(v);
    s_if.i_meas  = W'(i);
    s_if.t_meas  = W'(t);
    cfg_we       = we;
    peak_clr     = pclr;
    @(posedge clk);
    #1;
  endtask

  task automatic sampleV(input int v, input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b1, v, 100, 100);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 2000, 100, 100);
  endtask

  initial begin
    rst = 1'b1;
    s_if.s_valid = 1'b0;
    s_if.v_meas = '0;
    s_if.i_meas = '0;
    s_if.t_meas = '0;
    cfg_we = 1'b0;
    peak_clr = 1'b0;
    cfg_ov = 12'd3000;
    cfg_uv = 12'd1000;
    cfg_ot = 12'd3000;
    cfg_uc = 12'd3000;
    cfg_hyst = 12'd100;

    // Reset state
    #12;
    checkOutput("rst_ov", 32'(ov), 32'd0);
    checkOutput("rst_uv", 32'(uv), 32'd0);
    checkOutput("rst_stale", 32'(stale), 32'd0);
    checkOutput("rst_sready", 32'(s_if.s_ready), 32'd1);
    checkOutput("rst_peak_i", 32'(peak_i), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_en = 1'b1;
    applyStimulus(1'b0, 2000, 100, 100, 1'b1);

    // 1: reset in the middle of an ov run aborts the count
    sampleV(3001, 2);
    checkOutput("t1_ov_pre", 32'(ov), 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("t1_ov_rst", 32'(ov), 32'd0);
    checkOutput("t1_stale_rst", 32'(stale), 32'd0);
    checkOutput("t1_sready_rst", 32'(s_if.s_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b0, 2000, 100, 100, 1'b1);
    sampleV(3001, 1);
    checkOutput("t1_ov_after", 32'(ov), 32'd0);
    sampleV(2000, 1);

    // 2: three consecutive over samples set ov; a break restarts the run
    sampleV(3001, 2);
    checkOutput("t2_ov_2nd", 32'(ov), 32'd0);
    sampleV(3001, 1);
    checkOutput("t2_ov_3rd", 32'(ov), 32'd1);
    sampleV(2899, 3);
    checkOutput("t2_ov_rel", 32'(ov), 32'd0);
    sampleV(3001, 2);
    sampleV(2999, 1);
    sampleV(3001, 1);
    checkOutput("t2_ov_broken", 32'(ov), 32'd0);
    sampleV(3001, 2);
    checkOutput("t2_ov_reset", 32'(ov), 32'd1);

    // 3: inside the hysteresis band ov holds; below it ov releases
    sampleV(2950, 3);
    checkOutput("t3_ov_hyst", 32'(ov), 32'd1);
    sampleV(2899, 2);
    checkOutput("t3_ov_2nd", 32'(ov), 32'd1);
    sampleV(2899, 1);
    checkOutput("t3_ov_rel", 32'(ov), 32'd0);

    // 4: idle gaps do not break a run; stale after P_STALE idle cycles
    sampleV(3001, 2);
    idle(5);
    checkOutput("t4_ov_gap", 32'(ov), 32'd0);
    sampleV(3001, 1);
    checkOutput("t4_ov_set", 32'(ov), 32'd1);
    idle(15);
    checkOutput("t4_stale_15", 32'(stale), 32'd0);
    idle(1);
    checkOutput("t4_stale_16", 32'(stale), 32'd1);
    checkOutput("t4_ov_hold", 32'(ov), 32'd1);
    sampleV(3001, 1);
    checkOutput("t4_stale_clr", 32'(stale), 32'd0);
    sampleV(2899, 3);

    // 5: uv that can never release; same-cycle cfg_we uses old thresholds
    cfg_uv = 12'd4090;
    applyStimulus(1'b0, 2000, 100, 100, 1'b1);
    sampleV(500, 2);
    checkOutput("t5_uv_2nd", 32'(uv), 32'd0);
    sampleV(500, 1);
    checkOutput("t5_uv_set", 32'(uv), 32'd1);
    sampleV(4095, 5);
    checkOutput("t5_uv_stuck", 32'(uv), 32'd1);
    sampleV(2899, 3);
    checkOutput("t5_ov_rel", 32'(ov), 32'd0);
    sampleV(3001, 2);
    cfg_ov = 12'd4000;
    applyStimulus(1'b1, 3001, 100, 100, 1'b1);
    checkOutput("t5_ov_oldcfg", 32'(ov), 32'd1);

    // 6: ot and uc toggle together on the same edge
    for (int k = 0; k < 2; k++) applyStimulus(1'b1, 2000, 3001, 3001);
    checkOutput("t6_ot_2nd", 32'(ot), 32'd0);
    applyStimulus(1'b1, 2000, 3001, 3001);
    checkOutput("t6_ot_set", 32'(ot), 32'd1);
    checkOutput("t6_uc_set", 32'(uc), 32'd1);

    // 7: peak hold
    applyStimulus(1'b0, 2000, 100, 100, 1'b0, 1'b1);
    applyStimulus(1'b1, 2000, 100, 100);
    applyStimulus(1'b1, 2000, 900, 100);
    applyStimulus(1'b1, 2000, 300, 100);
`ifdef FDET_PEAK_HOLD_EN
    checkOutput("t7_peak_max", 32'(peak_i), 32'd900);
`else
    checkOutput("t7_peak_off", 32'(peak_i), 32'd0);
`endif
    applyStimulus(1'b1, 2000, 50, 100, 1'b0, 1'b1);
`ifdef FDET_PEAK_HOLD_EN
    checkOutput("t7_peak_clr", 32'(peak_i), 32'd50);
`else
    checkOutput("t7_peak_clr_off", 32'(peak_i), 32'd0);
`endif
    idle(2);

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
